// File: rtl/branch_predictor_gshare_pkg.sv
// Shared helpers for the gshare predictor: saturating counter arithmetic and sizing of
// the pending-lookup entries carried from decode to memory stage.
package bp_pkg;

    // Widest counter the helpers support; narrower counters are zero-extended into it.
    localparam int unsigned CNT_W_MAX = 4;

    typedef logic [CNT_W_MAX-1:0] cnt_max_t;

    localparam cnt_max_t CNT_ONE = cnt_max_t'(1);

    function automatic int unsigned idx_width(input int unsigned entries);
        return $clog2(entries);
    endfunction

    // A pending entry is the table index plus the prediction that was handed to decode.
    function automatic int unsigned pend_entry_w(input int unsigned idx_w);
        return idx_w + 1;
    endfunction

    function automatic cnt_max_t cnt_top(input int unsigned cnt_w);
        return cnt_max_t'((1 << cnt_w) - 1);
    endfunction

    function automatic cnt_max_t sat_inc(input cnt_max_t cnt, input int unsigned cnt_w);
        return (cnt == cnt_top(cnt_w)) ? cnt : cnt + CNT_ONE;
    endfunction

    function automatic cnt_max_t sat_dec(input cnt_max_t cnt);
        return (cnt == '0) ? cnt : cnt - CNT_ONE;
    endfunction

endpackage

// File: rtl/branch_predictor_gshare_if.sv
// Decode-lookup / memory-resolve bundle between the CPU pipeline and the gshare predictor.
interface branch_predictor_gshare_if;

    logic        branch_decode_sig;
    logic [31:0] in_addr;
    logic [31:0] offset;
    logic        branch_mem_sig;
    logic        actual_branch_decision;
    logic [29:0] branch_addr;
    logic        prediction;
    logic        mispredict;
    logic        q_overflow;
    logic        q_underflow;

    modport master (
        output branch_decode_sig,
        output in_addr,
        output offset,
        output branch_mem_sig,
        output actual_branch_decision,
        input  branch_addr,
        input  prediction,
        input  mispredict,
        input  q_overflow,
        input  q_underflow
    );

    modport slave (
        input  branch_decode_sig,
        input  in_addr,
        input  offset,
        input  branch_mem_sig,
        input  actual_branch_decision,
        output branch_addr,
        output prediction,
        output mispredict,
        output q_overflow,
        output q_underflow
    );

endinterface

// File: rtl/branch_predictor_gshare_pending_fifo.sv
// In-order queue of lookups awaiting resolution; simultaneous push and pop keep occupancy.
module bp_pending_fifo #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the block infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = ptr_next(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_next(rd_ptr_q);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: slot storage is left unreset; the pointers and count alone decide which slots are live.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == OCC_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/branch_predictor_gshare.sv
// gshare conditional-branch predictor: PC^history-indexed saturating counters, looked up at
// decode, trained in order at memory stage from a small pending queue.
module branch_predictor_gshare
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES  = 64,
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned CNT_INIT = 1,
    parameter int unsigned GHR_W    = 6,
    parameter int unsigned INFLIGHT = 2
) (
    input logic                      clk,
    input logic                      reset_n,
    branch_predictor_gshare_if.slave bp
);

    localparam int unsigned IDX_W   = idx_width(ENTRIES);
    localparam int unsigned ENTRY_W = pend_entry_w(IDX_W);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             pred;
    } pend_entry_t;

    logic [CNT_W-1:0]   cnt_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_upd;
    logic [IDX_W-1:0]   hist_idx;
    logic [IDX_W-1:0]   idx;
    logic               lookup;
    logic               resolve;
    logic               push_en;
    logic               pop_en;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] push_raw;
    logic [ENTRY_W-1:0] pop_raw;
    pend_entry_t        push_entry;
    pend_entry_t        pop_entry;
    logic               mispredict_q, mispredict_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               unused_addr_bits;

    assign lookup  = bp.branch_decode_sig;
    assign resolve = bp.branch_mem_sig;

    // Lookup reads the table and history as they stand before this edge's training.
    assign idx           = bp.in_addr[IDX_W+1:2] ^ hist_idx;
    assign bp.prediction = cnt_q[idx][CNT_W-1] & lookup;

    // A full queue still accepts a lookup when a resolve frees the head in the same cycle.
    assign pop_en  = resolve & ~fifo_empty;
    assign push_en = lookup & (~fifo_full | pop_en);

    assign push_entry = '{idx: idx, pred: bp.prediction};
    assign push_raw   = push_entry;
    assign pop_entry  = pend_entry_t'(pop_raw);

    bp_pending_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (INFLIGHT)
    ) u_pending (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_en),
        .pop_i   (pop_en),
        .data_i  (push_raw),
        .data_o  (pop_raw),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    generate
        if (GHR_W == 0) begin : g_bimodal
            assign hist_idx = '0;
        end else begin : g_history
            logic [GHR_W-1:0] ghr_q, ghr_d;

            // History advances only on a real resolve, oldest outcome shifting out the top.
            always_comb begin
                ghr_d = ghr_q;
                if (pop_en) ghr_d = GHR_W'({ghr_q, bp.actual_branch_decision});
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) ghr_q <= '0;
                else          ghr_q <= ghr_d;
            end

            assign hist_idx = IDX_W'(ghr_q);
        end
    endgenerate

    assign cnt_upd = bp.actual_branch_decision
                   ? CNT_W'(sat_inc(cnt_max_t'(cnt_q[pop_entry.idx]), CNT_W))
                   : CNT_W'(sat_dec(cnt_max_t'(cnt_q[pop_entry.idx])));

    // The counters are architectural state and must come back to the weak initial value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) cnt_q[i] <= CNT_W'(CNT_INIT);
        end else if (pop_en) begin
            cnt_q[pop_entry.idx] <= cnt_upd;
        end
    end

    always_comb begin
        mispredict_d = pop_en & (bp.actual_branch_decision != pop_entry.pred);
        overflow_d   = overflow_q | (lookup & fifo_full & ~pop_en);
        underflow_d  = underflow_q | (resolve & fifo_empty);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mispredict_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            mispredict_q <= mispredict_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign bp.mispredict  = mispredict_q;
    assign bp.q_overflow  = overflow_q;
    assign bp.q_underflow = underflow_q;

    // Word-granular target; the carry out of bit 29 falls away.
    assign bp.branch_addr = bp.in_addr[31:2] + bp.offset[31:2];

    assign unused_addr_bits = ^{bp.in_addr[1:0], bp.in_addr[31:IDX_W+2], bp.offset[1:0]};

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench: a bimodal (GHR_W=0) and a gshare (GHR_W=6) instance share one stimulus stream.
`timescale 1ns/1ps
module tb_branch_predictor_gshare;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dec;
    logic        mem_v;
    logic        act;
    logic [31:0] pc;
    logic [31:0] off;
    int          checks = 0;
    int          errors = 0;

    // Step tables, entry i is used on step i (left-most bit first).
    bit [0:8]  t2_tk   = 9'b111000010;
    bit [0:8]  t2_pred = 9'b011110000;
    bit [0:8]  t2_mis  = 9'b100110010;
    bit [0:11] t3_tk   = 12'b101010101010;
    bit [0:11] t3_pred = 12'b000000001010;
    bit [0:11] t3_mis  = 12'b101010100000;

    always #5 clk = ~clk;

    branch_predictor_gshare_if if_bim ();
    branch_predictor_gshare_if if_gs ();

    assign if_bim.branch_decode_sig      = dec;
    assign if_bim.in_addr                = pc;
    assign if_bim.offset                 = off;
    assign if_bim.branch_mem_sig         = mem_v;
    assign if_bim.actual_branch_decision = act;
    assign if_gs.branch_decode_sig       = dec;
    assign if_gs.in_addr                 = pc;
    assign if_gs.offset                  = off;
    assign if_gs.branch_mem_sig          = mem_v;
    assign if_gs.actual_branch_decision  = act;

    branch_predictor_gshare #(.GHR_W(0)) u_bim (
        .clk     (clk),
        .reset_n (reset_n),
        .bp      (if_bim)
    );

    branch_predictor_gshare u_gs (
        .clk     (clk),
        .reset_n (reset_n),
        .bp      (if_gs)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic pred_of(input bit sel);
        return sel ? if_gs.prediction : if_bim.prediction;
    endfunction

    function automatic logic mis_of(input bit sel);
        return sel ? if_gs.mispredict : if_bim.mispredict;
    endfunction

    task automatic drive(input logic d, input logic [31:0] a, input logic m, input logic t);
        dec   = d;
        pc    = a;
        mem_v = m;
        act   = t;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        dec   = 1'b0;
        mem_v = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        dec     = 1'b0;
        mem_v   = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic lookup_resolve(input string tag, input bit sel, input logic [31:0] a,
                                  input logic taken, input logic exp_pred, input logic exp_mis);
        drive(1'b1, a, 1'b0, 1'b0);
        check({tag, "_pred"}, 32'(pred_of(sel)), 32'(exp_pred));
        tick();
        check({tag, "_mis_idle"}, 32'(mis_of(sel)), 32'd0);
        drive(1'b0, a, 1'b1, taken);
        tick();
        check({tag, "_mis"}, 32'(mis_of(sel)), 32'(exp_mis));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        dec = 1'b0; mem_v = 1'b0; act = 1'b0; pc = '0; off = '0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        #1;

        // Reset state: flags clear, every counter weakly not-taken.
        check("rst_bim_mis", 32'(if_bim.mispredict), 32'd0);
        check("rst_bim_ovf", 32'(if_bim.q_overflow), 32'd0);
        check("rst_bim_unf", 32'(if_bim.q_underflow), 32'd0);
        check("rst_gs_mis", 32'(if_gs.mispredict), 32'd0);
        check("rst_gs_ovf", 32'(if_gs.q_overflow), 32'd0);
        check("rst_gs_unf", 32'(if_gs.q_underflow), 32'd0);
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 32'(i << 2), 1'b0, 1'b0);
            check($sformatf("rst_pred_bim_%0d", i), 32'(if_bim.prediction), 32'd0);
            check($sformatf("rst_pred_gs_%0d", i), 32'(if_gs.prediction), 32'd0);
        end

        // Bimodal training on PC 0x100: saturate high, then low, no wrap either way.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            lookup_resolve($sformatf("bim_%0d", i), 1'b0, 32'h100, t2_tk[i], t2_pred[i], t2_mis[i]);
        end

        // gshare on PC 0x200 with alternating outcomes: history separates the two cases.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            lookup_resolve($sformatf("gs_%0d", i), 1'b1, 32'h200, t3_tk[i], t3_pred[i], t3_mis[i]);
        end

        // Queue full: same-cycle lookup+resolve is legal, a further lookup overflows.
        do_reset();
        drive(1'b1, 32'h0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h4, 1'b0, 1'b0); tick();
        check("q_full_no_ovf", 32'(if_gs.q_overflow), 32'd0);
        drive(1'b1, 32'h8, 1'b1, 1'b1); tick();
        check("swap_no_ovf", 32'(if_gs.q_overflow), 32'd0);
        check("swap_mis", 32'(if_gs.mispredict), 32'd1);
        check("swap_no_unf", 32'(if_gs.q_underflow), 32'd0);
        drive(1'b1, 32'hC, 1'b0, 1'b0); tick();
        check("ovf_set", 32'(if_gs.q_overflow), 32'd1);
        tick();
        check("ovf_sticky", 32'(if_gs.q_overflow), 32'd1);
        check("ovf_mis_clr", 32'(if_gs.mispredict), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        check("pop1_no_unf", 32'(if_gs.q_underflow), 32'd0);
        check("pop1_mis", 32'(if_gs.mispredict), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        check("pop2_no_unf", 32'(if_gs.q_underflow), 32'd0);

        // Resolve on an empty queue: flag only, history and counters untouched.
        drive(1'b0, 32'h0, 1'b1, 1'b1); tick();
        check("unf_set", 32'(if_gs.q_underflow), 32'd1);
        check("unf_mis", 32'(if_gs.mispredict), 32'd0);
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        check("unf_ghr_kept", 32'(if_gs.prediction), 32'd1);
        tick();
        drive(1'b1, 32'h14, 1'b0, 1'b0);
        check("trained_low", 32'(if_gs.prediction), 32'd0);
        tick();

        // Asynchronous reset with two lookups pending.
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        check("async_ovf", 32'(if_gs.q_overflow), 32'd0);
        check("async_unf", 32'(if_gs.q_underflow), 32'd0);
        check("async_mis", 32'(if_gs.mispredict), 32'd0);
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        check("async_cnt0", 32'(if_gs.prediction), 32'd0);
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        check("async_ghr", 32'(if_gs.prediction), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        check("async_q_cleared", 32'(if_gs.q_underflow), 32'd1);
        check("async_q_mis", 32'(if_gs.mispredict), 32'd0);

        // Target arithmetic, including wrap past bit 29 and a negative offset.
        pc = 32'hFFFF_FFFC; off = 32'd8; #1;
        check("addr_wrap_gs", 32'(if_gs.branch_addr), 32'h0000_0001);
        check("addr_wrap_bim", 32'(if_bim.branch_addr), 32'h0000_0001);
        pc = 32'h0000_0100; off = 32'h0000_0040; #1;
        check("addr_fwd", 32'(if_gs.branch_addr), 32'h0000_0050);
        pc = 32'h0000_0200; off = 32'hFFFF_FFF8; #1;
        check("addr_back", 32'(if_gs.branch_addr), 32'h0000_007E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
